// File: rtl/medidor_pwm_if.sv
// rtl/medidor_pwm_if.sv - PWM line in, measured duty/period/status out
interface medidor_pwm_if #(
    parameter int W = 10
);
    logic         pwm_in;
    logic [W-1:0] duty;
    logic [W:0]   period;
    logic         valid;
    logic         steady;

    modport master (
        output pwm_in,
        input  duty, period, valid, steady
    );

    modport slave (
        input  pwm_in,
        output duty, period, valid, steady
    );
endinterface

// File: rtl/medidor_pwm.sv
// rtl/medidor_pwm.sv - PWM duty/period meter with stuck-line flag; optional debounce via PWM_MEAS_FILTER_EN
module medidor_pwm #(
    parameter int W       = 10,
    parameter int TIMEOUT = 1024,
    parameter int SYNC    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    medidor_pwm_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

    localparam logic [W:0] ONE = (W+1)'(1);
    localparam logic [W:0] TO  = (W+1)'(TIMEOUT);

    state_t        state, state_n;
    logic [SYNC-1:0] sync_q;
    logic          pwm_s;
    logic          level;
    logic          pwm_d;
    logic          rise;
    logic [W:0]    per_cnt, per_n;
    logic [W:0]    hi_cnt, hi_n;
    logic [W-1:0]  duty_q, duty_n;
    logic [W:0]    period_q, period_n;
    logic          valid_q, valid_n;
    logic          steady_q, steady_n;

    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC-2:0], bus.pwm_in};
    end

    assign pwm_s = sync_q[SYNC-1];

`ifdef PWM_MEAS_FILTER_EN
    // level follows pwm_s only once three consecutive samples agree on the new value
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], pwm_s};
            if (hist_q == {2{pwm_s}} && pwm_s != filt_q)
                filt_q <= pwm_s;
        end
    end

    assign level = filt_q;
`else
    assign level = pwm_s;
`endif

    assign rise = level & ~pwm_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            pwm_d    <= 1'b0;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            steady_q <= 1'b0;
        end else begin
            state    <= state_n;
            pwm_d    <= level;
            per_cnt  <= per_n;
            hi_cnt   <= hi_n;
            duty_q   <= duty_n;
            period_q <= period_n;
            valid_q  <= valid_n;
            steady_q <= steady_n;
        end
    end

    always_comb begin
        state_n  = state;
        per_n    = per_cnt;
        hi_n     = hi_cnt;
        duty_n   = duty_q;
        period_n = period_q;
        valid_n  = 1'b0;
        steady_n = steady_q;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = MEAS;
                    per_n   = ONE;
                    hi_n    = ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    duty_n   = hi_cnt[W-1:0] - W'(1);
                    period_n = per_cnt;
                    valid_n  = 1'b1;
                    per_n    = ONE;
                    hi_n     = ONE;
                end else if (per_cnt < TO) begin
                    per_n = per_cnt + ONE;
                    hi_n  = hi_cnt + {{W{1'b0}}, level};
                end else begin
                    // no edge within TIMEOUT: one final report of the static level
                    state_n  = STUCK;
                    steady_n = 1'b1;
                    period_n = '0;
                    valid_n  = 1'b1;
                    duty_n   = {W{level}};
                end
            end
            STUCK: begin
                duty_n = {W{level}};
                if (rise) begin
                    state_n  = MEAS;
                    steady_n = 1'b0;
                    per_n    = ONE;
                    hi_n     = ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.duty   = duty_q;
    assign bus.period = period_q;
    assign bus.valid  = valid_q;
    assign bus.steady = steady_q;
endmodule

// File: tb/tb_medidor_pwm.sv
// tb/tb_medidor_pwm.sv - directed bench for medidor_pwm
module tb_medidor_pwm;
    localparam int W = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    medidor_pwm_if #(.W(W)) bus();

    medidor_pwm #(.W(W), .TIMEOUT(1024), .SYNC(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int ev_d[$];
    int ev_p[$];
    int ev_s[$];
    int dbl = 0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            ev_d.push_back(int'(bus.duty));
            ev_p.push_back(int'(bus.period));
            ev_s.push_back(int'(bus.steady));
        end
        if (bus.valid === 1'b1 && prev_v === 1'b1) dbl++;
        prev_v = bus.valid;
    end

    task automatic drv(input logic lv, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.pwm_in = lv;
        end
    endtask

    task automatic periods(input int hi, input int per, input int n);
        repeat (n) begin
            drv(1'b1, hi);
            drv(1'b0, per - hi);
        end
    endtask

    task automatic tail();
        drv(1'b1, 1);
        drv(1'b0, 10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        drv(1'b0, 4);
    endtask

    task automatic test_reset();
        int b;
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.pwm_in = i[0] ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        total++; if (bus.duty !== '0)   begin bad++; $display("FAIL reset_duty got=%0d want=0", bus.duty); end
        total++; if (bus.period !== '0) begin bad++; $display("FAIL reset_period got=%0d want=0", bus.period); end
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.valid); end
        total++; if (bus.steady !== 1'b0) begin bad++; $display("FAIL reset_steady got=%0b want=0", bus.steady); end
        bus.pwm_in = 1'b0;
        reset_n = 1'b1;
        drv(1'b0, 8);
        b = ev_d.size();
        periods(512, 1024, 1);
        total++; if (ev_d.size() !== b) begin bad++; $display("FAIL reset_one_rise got=%0d want=0 valids", ev_d.size() - b); end
        tail();
        total++;
        if (ev_d.size() !== b + 1) begin
            bad++; $display("FAIL reset_two_rise got=%0d want=1 valids", ev_d.size() - b);
        end else if (ev_d[b] !== 511 || ev_p[b] !== 1024) begin
            bad++; $display("FAIL reset_first_meas got=%0d/%0d want=511/1024", ev_d[b], ev_p[b]);
        end
    endtask

    task automatic test_duty(input string nm, input int hi, input int per, input int n);
        int b;
        do_reset();
        b = ev_d.size();
        periods(hi, per, n);
        tail();
        total++;
        if (ev_d.size() !== b + n) begin
            bad++; $display("FAIL %s_count got=%0d want=%0d", nm, ev_d.size() - b, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                total++;
                if (ev_d[b+k] !== hi - 1 || ev_p[b+k] !== per || ev_s[b+k] !== 0) begin
                    bad++;
                    $display("FAIL %s_ev%0d got=%0d/%0d/%0d want=%0d/%0d/0", nm, k,
                             ev_d[b+k], ev_p[b+k], ev_s[b+k], hi - 1, per);
                end
            end
        end
    endtask

    task automatic test_stuck();
        int b;
        int xd[5];
        int xp[5];
        int xs[5];
        xd = '{511, 511, 1023, 511, 511};
        xp = '{1024, 1024, 0, 1024, 1024};
        xs = '{0, 0, 1, 0, 0};
        do_reset();
        b = ev_d.size();
        periods(512, 1024, 2);
        drv(1'b1, 1100);
        total++; if (bus.steady !== 1'b1) begin bad++; $display("FAIL stuck_steady got=%0b want=1", bus.steady); end
        total++; if (bus.duty !== 10'd1023) begin bad++; $display("FAIL stuck_duty_hi got=%0d want=1023", bus.duty); end
        drv(1'b0, 600);
        total++; if (bus.duty !== 10'd0) begin bad++; $display("FAIL stuck_duty_lo got=%0d want=0", bus.duty); end
        total++; if (ev_d.size() !== b + 3) begin bad++; $display("FAIL stuck_no_extra got=%0d want=3 valids", ev_d.size() - b); end
        drv(1'b1, 10);
        total++; if (bus.steady !== 1'b0) begin bad++; $display("FAIL recover_steady got=%0b want=0", bus.steady); end
        total++; if (ev_d.size() !== b + 3) begin bad++; $display("FAIL recover_first_rise got=%0d want=3 valids", ev_d.size() - b); end
        drv(1'b1, 502);
        drv(1'b0, 512);
        periods(512, 1024, 1);
        tail();
        total++;
        if (ev_d.size() !== b + 5) begin
            bad++; $display("FAIL stuck_count got=%0d want=5", ev_d.size() - b);
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++;
                if (ev_d[b+k] !== xd[k] || ev_p[b+k] !== xp[k] || ev_s[b+k] !== xs[k]) begin
                    bad++;
                    $display("FAIL stuck_ev%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", k,
                             ev_d[b+k], ev_p[b+k], ev_s[b+k], xd[k], xp[k], xs[k]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int b;
        do_reset();
        periods(512, 1024, 1);
        drv(1'b1, 300);
        total++; if (bus.duty !== 10'd511) begin bad++; $display("FAIL midrst_pre got=%0d want=511", bus.duty); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.duty !== '0 || bus.period !== '0 || bus.valid !== 1'b0 || bus.steady !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%0d/%0d/%0b/%0b want=0/0/0/0",
                     bus.duty, bus.period, bus.valid, bus.steady);
        end
        drv(1'b1, 210);
        drv(1'b0, 400);
        reset_n = 1'b1;
        drv(1'b0, 110);
        b = ev_d.size();
        periods(512, 1024, 1);
        total++; if (ev_d.size() !== b) begin bad++; $display("FAIL midrst_one_rise got=%0d want=0 valids", ev_d.size() - b); end
        tail();
        total++;
        if (ev_d.size() !== b + 1) begin
            bad++; $display("FAIL midrst_count got=%0d want=1", ev_d.size() - b);
        end else if (ev_d[b] !== 511 || ev_p[b] !== 1024) begin
            bad++; $display("FAIL midrst_meas got=%0d/%0d want=511/1024", ev_d[b], ev_p[b]);
        end
    endtask

    task automatic test_glitch();
        int b;
        int n;
        int xd[3];
        int xp[3];
`ifdef PWM_MEAS_FILTER_EN
        n = 2;
        xd = '{511, 511, 0};
        xp = '{1024, 1024, 0};
`else
        n = 3;
        xd = '{511, 199, 310};
        xp = '{1024, 201, 823};
`endif
        do_reset();
        b = ev_d.size();
        periods(512, 1024, 1);
        drv(1'b1, 200);
        drv(1'b0, 1);
        drv(1'b1, 311);
        drv(1'b0, 512);
        tail();
        total++;
        if (ev_d.size() !== b + n) begin
            bad++; $display("FAIL glitch_count got=%0d want=%0d", ev_d.size() - b, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                total++;
                if (ev_d[b+k] !== xd[k] || ev_p[b+k] !== xp[k]) begin
                    bad++;
                    $display("FAIL glitch_ev%0d got=%0d/%0d want=%0d/%0d", k,
                             ev_d[b+k], ev_p[b+k], xd[k], xp[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
`ifdef PWM_MEAS_FILTER_EN
        test_duty("short", 3, 6, 4);
`else
        test_duty("min_period", 1, 2, 5);
`endif
        total++; if (dbl !== 0) begin bad++; $display("FAIL valid_consecutive got=%0d want=0", dbl); end
    endtask

    initial begin
        bus.pwm_in = 1'b0;
        test_reset();
        test_duty("half", 512, 1024, 3);
`ifndef PWM_MEAS_FILTER_EN
        test_duty("narrow", 1, 1024, 3);
`endif
        test_duty("p100", 25, 100, 3);
        test_stuck();
        test_mid_reset();
        test_glitch();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
